simaudio_i2s_main: RTL and testbench
====================================

// Module: simaudio_i2s_main
// PURPOSE
// - Top-level I2S master for the simulated-audio FPGA path. Derives I2S bit clock and word clock
//   from the LTC6905 master clock (24.576 MHz nominal) and deserialises 24-bit stereo ADC data on I2S_din0.
// - Re-serialises each captured sample on dout in standard I2S format, one frame later (loopback to DAC).
// PARAMETERS
// - WIDTH     default 24  audio sample width, bits per channel
// - SLOT      default 32  bclk periods per channel slot (frame = 2*SLOT bclk); SLOT >= WIDTH+1
// - BCLK_DIV  default 4   mclk periods per bclk period; even, >= 2 (24.576 MHz/4/64 = 96 kHz frames)
// PORTS
// - mclk_in       in   1  master clock from LTC6905; the only clock
// - rst           in   1  reset, asynchronous, active-high
// - I2S_wclk_out  out  1  word clock (LRCLK): 0 = left, 1 = right
// - I2S_bclk_out  out  1  bit clock, 50% duty, mclk_in/BCLK_DIV
// - I2S_din0      in   1  serial ADC data, I2S format, MSB first
// - dout          out  1  serial DAC data, I2S format, MSB first
// BEHAVIOUR
// - One clock (mclk_in); every register resets asynchronously on rst=1 and is clocked on posedge mclk_in.
// - Reset values: I2S_bclk_out=0, I2S_wclk_out=0, dout=0, divider=0, bit counter=0, all shift/hold regs=0.
// - Clock gen: divider counts 0..BCLK_DIV-1; bclk toggles at count BCLK_DIV/2-1 and BCLK_DIV-1.
//   The first bclk rise occurs BCLK_DIV/2 mclk cycles after rst deasserts.
// - Bit counter b (0..2*SLOT-1) advances on each bclk falling edge (mclk cycle in which bclk goes 1->0);
//   wraps 2*SLOT-1 -> 0. I2S_wclk_out = (b >= SLOT), updated in the same cycle as the bclk fall.
// - Slot position s = b mod SLOT. Standard I2S 1-bit delay: MSB occupies s=1, LSB occupies s=WIDTH;
//   positions s=0 and s=WIDTH+1..SLOT-1 carry no data.
// - Receive: I2S_din0 sampled in the mclk cycle where bclk goes 0->1; shifted in for s=1..WIDTH.
//   Samples at other positions are ignored.
// - Receive commit: at the bclk rise of s=WIDTH, the completed word is written to rx_left (wclk=0)
//   or rx_right (wclk=1).
// - Transmit: at every bclk fall the next bit is driven on dout.
//   - At s=0, tx shift register loads the hold word of the channel now starting (left if wclk=0).
//   - s=1..WIDTH: dout = tx MSB..LSB. All other positions: dout=0.
// - Latency: sample received in frame N is output on dout in frame N+1, same channel, bit-exact.
// - A commit and a tx load of the same channel never coincide (commit at s=WIDTH < SLOT, load at s=0).
//   Consequently no word is ever corrupted.
// - Reset mid-frame: all outputs return to reset values immediately (async); the partial word is discarded.
//   On rst release the frame restarts at b=0, left channel. Hold regs are 0, so the first frame's dout is 0.
// - I2S_din0 is sampled only at bclk rises; its value between rises is don't-care.
// STRUCTURE
// - Shared package: WIDTH/SLOT/BCLK_DIV defaults and the channel encoding (LEFT=0, RIGHT=1) as constants.
// - One natural sub-module: i2s_clkgen (divider, bit counter, bclk/wclk, rise/fall strobes).
//   Rx/tx shift and hold logic live in the top.
// TESTING
// - Reset: assert rst for 5 mclk -> bclk=0, wclk=0, dout=0. Release -> first bclk rise after 2 mclk (BCLK_DIV=4).
// - Clock ratios: run 3 frames -> bclk period 4 mclk, 50% duty; wclk period 256 mclk, high 128 / low 128.
//   wclk transitions coincide with bclk falls.
// - Loopback: drive left=24'hA5A5A5, right=24'h000001 (MSB at s=1) in frame 1.
//   -> Frame 2: dout carries A5A5A5 in the left slot and 000001 in the right slot, both at s=1..24.
// - Padding: drive I2S_din0=1 at s=0 and s=25..31 with data 24'h000000.
//   -> Next frame: dout=0 for the whole frame (padding ignored).
// - Alternating data: frames of 24'h800000 / 24'h7FFFFF, changing every frame.
//   -> dout echoes each word exactly one frame later with no bit slip.
// - Reset mid-word: assert rst at s=12 of the right slot -> outputs 0 at once.
//   After release, the frame restarts left and previous hold data is not emitted.

Source files
------------

// File: rtl/simaudio_i2s_main_pkg.sv
// Shared constants and slot helpers for the simulated-audio I2S master.
package simaudio_i2s_main_pkg;

    localparam int WIDTH_DEF    = 24;
    localparam int SLOT_DEF     = 32;
    localparam int BCLK_DIV_DEF = 4;

    typedef enum logic {
        CH_LEFT  = 1'b0,
        CH_RIGHT = 1'b1
    } chan_e;

    function automatic int slot_pos(input int b, input int slot);
        return (b >= slot) ? b - slot : b;
    endfunction

    function automatic chan_e chan_of(input int b, input int slot);
        return (b >= slot) ? CH_RIGHT : CH_LEFT;
    endfunction

    // Standard I2S one-bit delay: data sits at slot positions 1..width.
    function automatic logic is_data_pos(input int s, input int width);
        return (s >= 1) && (s <= width);
    endfunction

endpackage

// File: rtl/simaudio_i2s_main_if.sv
// Serial I2S bus between the FPGA master and the ADC/DAC codec.
interface simaudio_i2s_main_if;

    logic I2S_wclk_out;
    logic I2S_bclk_out;
    logic I2S_din0;
    logic dout;

    modport master (
        output I2S_wclk_out,
        output I2S_bclk_out,
        output dout,
        input  I2S_din0
    );

    modport slave (
        input  I2S_wclk_out,
        input  I2S_bclk_out,
        input  dout,
        output I2S_din0
    );

endinterface

// File: rtl/simaudio_i2s_main_clkgen.sv
// Bit/word clock generator: divides mclk into bclk, counts bit positions in the frame,
// and exposes one-cycle strobes for the mclk cycles in which bclk rises and falls.
module simaudio_i2s_main_clkgen #(
    parameter int SLOT     = 32,
    parameter int BCLK_DIV = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    output logic                        bclk,
    output logic                        wclk,
    output logic                        rise,
    output logic                        fall,
    output logic [$clog2(2*SLOT)-1:0]   bit_cnt,
    output logic [$clog2(2*SLOT)-1:0]   bit_nxt
);

    localparam int DW = (BCLK_DIV > 2) ? $clog2(BCLK_DIV) : 1;
    localparam int BW = $clog2(2 * SLOT);

    localparam logic [DW-1:0] DIV_HALF = DW'(BCLK_DIV / 2 - 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(BCLK_DIV - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(2 * SLOT - 1);
    localparam logic [BW-1:0] SLOT_B   = BW'(SLOT);

    logic [DW-1:0] div;

    // bclk is always low at the half count and high at the last count, so the
    // two toggle points are exactly the rise and fall.
    assign rise    = (div == DIV_HALF);
    assign fall    = (div == DIV_LAST);
    assign bit_nxt = (bit_cnt == BIT_LAST) ? '0 : bit_cnt + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div     <= '0;
            bclk    <= 1'b0;
            wclk    <= 1'b0;
            bit_cnt <= '0;
        end else begin
            div <= fall ? '0 : div + 1'b1;
            if (rise) begin
                bclk <= 1'b1;
            end
            if (fall) begin
                bclk    <= 1'b0;
                bit_cnt <= bit_nxt;
                wclk    <= (bit_nxt >= SLOT_B);
            end
        end
    end

endmodule

// File: rtl/simaudio_i2s_main.sv
// I2S master: generates bclk/wclk from mclk, captures stereo ADC words on I2S_din0 and
// replays each one on dout a frame later in the same channel slot.
module simaudio_i2s_main
    import simaudio_i2s_main_pkg::*;
#(
    parameter int WIDTH    = WIDTH_DEF,
    parameter int SLOT     = SLOT_DEF,
    parameter int BCLK_DIV = BCLK_DIV_DEF
) (
    input  logic                mclk_in,
    input  logic                rst,
    simaudio_i2s_main_if.master i2s
);

    localparam int BW = $clog2(2 * SLOT);

    logic          bclk;
    logic          wclk;
    logic          rise;
    logic          fall;
    logic [BW-1:0] bit_cnt;
    logic [BW-1:0] bit_nxt;

    int    s_cur;
    int    s_nxt;
    chan_e ch_cur;
    chan_e ch_nxt;

    logic [WIDTH-2:0]      rx_sr;
    logic [WIDTH-1:0]      rx_word;
    logic [1:0][WIDTH-1:0] rx_hold;
    logic [WIDTH-1:0]      tx_sr;
    logic                  dout_q;

    simaudio_i2s_main_clkgen #(
        .SLOT     (SLOT),
        .BCLK_DIV (BCLK_DIV)
    ) u_clkgen (
        .clk     (mclk_in),
        .rst     (rst),
        .bclk    (bclk),
        .wclk    (wclk),
        .rise    (rise),
        .fall    (fall),
        .bit_cnt (bit_cnt),
        .bit_nxt (bit_nxt)
    );

    always_comb begin
        s_cur  = slot_pos(int'(bit_cnt), SLOT);
        s_nxt  = slot_pos(int'(bit_nxt), SLOT);
        ch_cur = chan_of(int'(bit_cnt), SLOT);
        ch_nxt = chan_of(int'(bit_nxt), SLOT);
    end

    assign rx_word = {rx_sr, i2s.I2S_din0};

    // Receive: shift on bclk rise, commit the full word at the last data position.
    always_ff @(posedge mclk_in or posedge rst) begin
        if (rst) begin
            rx_sr   <= '0;
            rx_hold <= '0;
        end else if (rise && is_data_pos(s_cur, WIDTH)) begin
            rx_sr <= rx_word[WIDTH-2:0];
            if (s_cur == WIDTH) begin
                rx_hold[ch_cur] <= rx_word;
            end
        end
    end

    // Transmit: each fall drives the bit for the position that is about to start.
    always_ff @(posedge mclk_in or posedge rst) begin
        if (rst) begin
            tx_sr  <= '0;
            dout_q <= 1'b0;
        end else if (fall) begin
            if (s_nxt == 0) begin
                tx_sr  <= rx_hold[ch_nxt];
                dout_q <= 1'b0;
            end else if (is_data_pos(s_nxt, WIDTH)) begin
                dout_q <= tx_sr[WIDTH-1];
                tx_sr  <= {tx_sr[WIDTH-2:0], 1'b0};
            end else begin
                dout_q <= 1'b0;
            end
        end
    end

    assign i2s.I2S_bclk_out = bclk;
    assign i2s.I2S_wclk_out = wclk;
    assign i2s.dout         = dout_q;

endmodule

// File: tb/tb_simaudio_i2s_main.sv
// Scoreboard bench: a bclk-driven codec model feeds random/directed stereo words and
// queues the expected loopback words; an independent monitor decodes dout and compares.
module tb_simaudio_i2s_main;

    localparam int WIDTH    = 24;
    localparam int SLOT     = 32;
    localparam int BCLK_DIV = 4;
    localparam int FRAME    = 2 * SLOT;

    typedef struct {
        logic [WIDTH-1:0] l;
        logic [WIDTH-1:0] r;
        bit               pad_ones;
    } stim_t;

    logic mclk_in = 1'b0;
    logic rst     = 1'b1;

    simaudio_i2s_main_if bus();

    simaudio_i2s_main #(
        .WIDTH    (WIDTH),
        .SLOT     (SLOT),
        .BCLK_DIV (BCLK_DIV)
    ) dut (
        .mclk_in (mclk_in),
        .rst     (rst),
        .i2s     (bus)
    );

    always #5 mclk_in = ~mclk_in;

    int n_vec = 0;
    int n_err = 0;

    logic [WIDTH-1:0] exp_q[$];
    stim_t            stim_q[$];

    // codec-side transmitter state
    int               p;
    bit               drv_prevb;
    logic [WIDTH-1:0] cur_l;
    logic [WIDTH-1:0] cur_r;
    bit               cur_pad;

    task automatic chk(input string name, input int act, input int expv);
        n_vec++;
        if (act != expv) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic start_frame();
        stim_t st;
        if (stim_q.size() > 0) begin
            st = stim_q.pop_front();
        end else begin
            st.l        = WIDTH'($urandom);
            st.r        = WIDTH'($urandom);
            st.pad_ones = 1'($urandom_range(0, 1));
        end
        cur_l   = st.l;
        cur_r   = st.r;
        cur_pad = st.pad_ones;
        exp_q.push_back(st.l);
        exp_q.push_back(st.r);
    endtask

    function automatic logic din_bit(input int pos);
        int               s = pos % SLOT;
        logic [WIDTH-1:0] w = (pos >= SLOT) ? cur_r : cur_l;
        if (s >= 1 && s <= WIDTH) return w[WIDTH - s];
        return cur_pad ? 1'b1 : 1'($urandom_range(0, 1));
    endfunction

    task automatic drv_step(output bit wrapped);
        logic bc;
        wrapped = 1'b0;
        @(negedge mclk_in);
        bc = bus.I2S_bclk_out;
        if (drv_prevb && !bc) begin
            p = (p + 1) % FRAME;
            if (p == 0) begin
                start_frame();
                wrapped = 1'b1;
            end
            bus.I2S_din0 = din_bit(p);
        end
        drv_prevb = bc;
    endtask

    task automatic run_frames(input int n);
        int wraps  = 0;
        int budget = n * FRAME * BCLK_DIV + 16;
        bit w;
        while (wraps < n && budget > 0) begin
            drv_step(w);
            if (w) wraps++;
            budget--;
        end
        if (wraps < n) begin
            n_vec++; n_err++;
            $display("FAIL run_frames timeout: got %0d frames, expected %0d", wraps, n);
        end
    endtask

    task automatic run_to_pos(input int target);
        int budget = FRAME * BCLK_DIV + 16;
        bit w;
        while (p != target && budget > 0) begin
            drv_step(w);
            budget--;
        end
        if (p != target) begin
            n_vec++; n_err++;
            $display("FAIL run_to_pos timeout: got pos %0d, expected %0d", p, target);
        end
    endtask

    task automatic reset_dut(input int n);
        @(negedge mclk_in);
        #1 rst = 1'b1;
        #1;
        chk("rst_async_bclk", bus.I2S_bclk_out, 0);
        chk("rst_async_wclk", bus.I2S_wclk_out, 0);
        chk("rst_async_dout", bus.dout, 0);
        repeat (n) @(posedge mclk_in);
        #1;
        chk("rst_hold_bclk", bus.I2S_bclk_out, 0);
        chk("rst_hold_wclk", bus.I2S_wclk_out, 0);
        chk("rst_hold_dout", bus.dout, 0);
        @(negedge mclk_in);
        #1;
        exp_q.delete();
        rst       = 1'b0;
        p         = 0;
        drv_prevb = 1'b0;
        // hold registers are empty, so the first frame out is silence
        exp_q.push_back('0);
        exp_q.push_back('0);
        start_frame();
        bus.I2S_din0 = din_bit(0);
        @(posedge mclk_in); #1;
        chk("first_rise_early", bus.I2S_bclk_out, 0);
        @(posedge mclk_in); #1;
        chk("first_rise", bus.I2S_bclk_out, 1);
    endtask

    // monitor: decodes dout at every bclk rise and checks clock ratios
    int               rcnt;
    int               brun;
    int               wrun;
    bit               b_seen;
    bit               w_seen;
    logic             m_prevb;
    logic             m_prevw;
    logic [WIDTH-1:0] word;
    logic             pad;

    always @(negedge mclk_in) begin
        if (rst) begin
            rcnt = 0; brun = 0; wrun = 0; b_seen = 0; w_seen = 0;
            m_prevb = 1'b0; m_prevw = 1'b0; word = '0; pad = 1'b0;
        end else begin
            logic bc;
            logic wc;
            int   pos;
            int   s;
            logic [WIDTH-1:0] e;
            bc = bus.I2S_bclk_out;
            wc = bus.I2S_wclk_out;
            brun++;
            wrun++;
            if (bc != m_prevb) begin
                if (b_seen) chk("bclk_half_period", brun, BCLK_DIV / 2);
                b_seen = 1'b1;
                brun   = 0;
            end
            if (wc != m_prevw) begin
                chk("wclk_on_bclk_fall", {m_prevb, bc}, 2);
                if (w_seen) chk("wclk_half_period", wrun, SLOT * BCLK_DIV);
                w_seen = 1'b1;
                wrun   = 0;
            end
            if (bc && !m_prevb) begin
                pos = rcnt % FRAME;
                rcnt++;
                s = pos % SLOT;
                chk("wclk_level", wc, (pos >= SLOT) ? 1 : 0);
                if (s >= 1 && s <= WIDTH) word = {word[WIDTH-2:0], bus.dout};
                else                      pad  = pad | bus.dout;
                if (s == SLOT - 1) begin
                    if (exp_q.size() == 0) begin
                        n_vec++; n_err++;
                        $display("FAIL scoreboard_underflow: got word %0h, expected none queued", word);
                    end else begin
                        e = exp_q.pop_front();
                        chk((pos >= SLOT) ? "right_word" : "left_word", word, e);
                        chk("padding_zero", pad, 0);
                    end
                    word = '0;
                    pad  = 1'b0;
                end
            end
            m_prevb = bc;
            m_prevw = wc;
        end
    end

    initial begin
        stim_t st;
        bus.I2S_din0 = 1'b0;
        st = '{l: 24'hA5A5A5, r: 24'h000001, pad_ones: 1'b0}; stim_q.push_back(st);
        st = '{l: 24'h000000, r: 24'h000000, pad_ones: 1'b1}; stim_q.push_back(st);
        for (int i = 0; i < 4; i++) begin
            st.l        = (i % 2 == 0) ? 24'h800000 : 24'h7FFFFF;
            st.r        = (i % 2 == 0) ? 24'h7FFFFF : 24'h800000;
            st.pad_ones = 1'b0;
            stim_q.push_back(st);
        end

        reset_dut(5);
        run_frames(12);

        // right hold all ones, then reset inside the next right slot
        st = '{l: WIDTH'($urandom), r: 24'hFFFFFF, pad_ones: 1'b0}; stim_q.push_back(st);
        st = '{l: WIDTH'($urandom), r: WIDTH'($urandom), pad_ones: 1'b0}; stim_q.push_back(st);
        run_frames(2);
        run_to_pos(SLOT + 12);
        chk("pre_rst_wclk", bus.I2S_wclk_out, 1);
        chk("pre_rst_dout", bus.dout, 1);
        reset_dut(5);
        run_frames(5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
